// File: rtl/load_store_unit.sv
// load_store_unit: sequencer between the execute stage and a word-addressed
// data memory. One request per handshake, one response per request.
// Optional feature macro: LSU_SUBWORD_EN (byte/half accesses with
// read-modify-write stores). Without it every access is a word access.
module load_store_unit #(
   parameter int ADDR_W  = 6,
   parameter int MEM_LAT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic [4:0]        resp_rd,
   output logic              resp_misalign,
   output logic              busy
);

`ifdef LSU_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state, state_nxt;
   logic [2:0]        lat_cnt;
   logic              write_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        lane_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       resp_data_q;
   logic [4:0]        resp_rd_q;
   logic              mis_q;

   logic              accept;
   logic              mis_now;
   logic              rmw_now;
   logic              read_last;

   // Alignment rule: with sub-word support byte is always aligned and half
   // needs addr[0]=0; everything else is treated as a word.
   function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] size);
      logic res;
      res = (lo != 2'b00);
      if (SUBWORD && size == 2'b00) res = 1'b0;
      if (SUBWORD && size == 2'b01) res = lo[0];
      return res;
   endfunction

   // Shift the addressed lane down to bit 0 and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      res = word;
      sh  = word >> {lane, 3'b000};
      if (SUBWORD && size == 2'b00) begin
         res = {{24{~uns & sh[7]}}, sh[7:0]};
      end else if (SUBWORD && size == 2'b01) begin
         sh  = word >> {lane[1], 4'b0000};
         res = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      return res;
   endfunction

   // Replace only the addressed byte/half lane of the word read back.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] mask;
      logic [31:0] data;
      if (size == 2'b00) begin
         mask = 32'h0000_00FF << {lane, 3'b000};
         data = {24'h00_0000, wdata[7:0]} << {lane, 3'b000};
      end else begin
         mask = 32'h0000_FFFF << {lane[1], 4'b0000};
         data = {16'h0000, wdata[15:0]} << {lane[1], 4'b0000};
      end
      return (word & ~mask) | (data & mask);
   endfunction

   assign accept    = (state == IDLE) && req_valid;
   assign mis_now   = misaligned(req_addr[1:0], req_size);
   assign rmw_now   = SUBWORD && req_write && !req_size[1];
   assign read_last = (lat_cnt == 3'(MEM_LAT));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (mis_now)                     state_nxt = RESP;
               else if (!req_write || rmw_now)  state_nxt = READ;
               else                             state_nxt = WRITE;
            end
         end
         READ:    if (read_last) state_nxt = write_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; data outputs are gated so they read zero when idle
   always_comb begin
      req_ready     = (state == IDLE);
      busy          = (state != IDLE);
      mem_re        = (state == READ);
      mem_we        = (state == WRITE);
      resp_valid    = (state == RESP);
      mem_addr      = addr_q;
      mem_wdata     = mem_we ? wdata_q : '0;
      resp_data     = resp_valid ? resp_data_q : '0;
      resp_rd       = resp_valid ? resp_rd_q : '0;
      resp_misalign = resp_valid & mis_q;
   end

   // Request capture, read wait counting and load/merge data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt     <= '0;
         write_q     <= 1'b0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         lane_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         resp_data_q <= '0;
         resp_rd_q   <= '0;
         mis_q       <= 1'b0;
      end else begin
         if (accept) begin
            lat_cnt     <= '0;
            write_q     <= req_write;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            lane_q      <= req_addr[1:0];
            addr_q      <= req_addr[ADDR_W+1:2];
            wdata_q     <= req_wdata;
            resp_data_q <= '0;
            resp_rd_q   <= req_write ? 5'd0 : req_rd;
            mis_q       <= mis_now;
         end else if (state == READ) begin
            lat_cnt <= lat_cnt + 3'd1;
            if (read_last) begin
               if (write_q) wdata_q     <= store_merge(mem_rdata, wdata_q, lane_q, size_q);
               else         resp_data_q <= load_extract(mem_rdata, lane_q, size_q, uns_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table on a MEM_LAT=0 instance
// plus hand sequences for back-to-back rate, a MEM_LAT=3 instance with
// writeback stall, and reset during a write.
module tb_load_store_unit;

   logic clk;
   logic rst_n;

   logic        req_valid0, req_ready0, req_write0, req_unsigned0;
   logic [1:0]  req_size0;
   logic [31:0] req_addr0, req_wdata0;
   logic [4:0]  req_rd0;
   logic [5:0]  mem_addr0;
   logic [31:0] mem_wdata0, mem_rdata0, resp_data0;
   logic        mem_we0, mem_re0, resp_valid0, resp_ready0, resp_misalign0, busy0;
   logic [4:0]  resp_rd0;

   logic        req_valid3, req_ready3, req_write3, req_unsigned3;
   logic [1:0]  req_size3;
   logic [31:0] req_addr3, req_wdata3;
   logic [4:0]  req_rd3;
   logic [5:0]  mem_addr3;
   logic [31:0] mem_wdata3, mem_rdata3, resp_data3;
   logic        mem_we3, mem_re3, resp_valid3, resp_ready3, resp_misalign3, busy3;
   logic [4:0]  resp_rd3;

   int unsigned checks = 0;
   int unsigned fails  = 0;

   load_store_unit #(.ADDR_W(6), .MEM_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_size(req_size0), .req_unsigned(req_unsigned0), .req_addr(req_addr0),
      .req_wdata(req_wdata0), .req_rd(req_rd0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_re(mem_re0),
      .mem_rdata(mem_rdata0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_data(resp_data0),
      .resp_rd(resp_rd0), .resp_misalign(resp_misalign0), .busy(busy0)
   );

   load_store_unit #(.ADDR_W(6), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
      .req_size(req_size3), .req_unsigned(req_unsigned3), .req_addr(req_addr3),
      .req_wdata(req_wdata3), .req_rd(req_rd3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_re(mem_re3),
      .mem_rdata(mem_rdata3),
      .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
      .resp_rd(resp_rd3), .resp_misalign(resp_misalign3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models with a bench-side preload port
   logic [31:0] mem0 [64];
   logic [31:0] mem3 [64];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   always @(posedge clk) begin
      if (mem_we0)     mem0[mem_addr0] <= mem_wdata0;
      else if (pre_we) mem0[pre_idx]   <= pre_val;
      if (mem_we3)     mem3[mem_addr3] <= mem_wdata3;
      else if (pre_we) mem3[pre_idx]   <= pre_val;
   end
   assign mem_rdata0 = mem0[mem_addr0];
   assign mem_rdata3 = mem3[mem_addr3];

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [4:0]  exp_rd;
      logic        mis;
      int unsigned lat;
      int unsigned re;
      int unsigned we;
      logic [31:0] mem;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                               input logic [31:0] data, input logic [4:0] exp_rd, input logic mis,
                               input int unsigned lat, input int unsigned re, input int unsigned we,
                               input logic [31:0] mem);
      vec_t v;
      v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
      v.data = data; v.exp_rd = exp_rd; v.mis = mis; v.lat = lat; v.re = re; v.we = we; v.mem = mem;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx; pre_val = val;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic run_vec(input int unsigned n, input vec_t v);
      int unsigned lat, re_n, we_n;
      logic addr_ok, wd_ok;
      logic [5:0] idx;
      idx = v.addr[7:2];
      @(negedge clk);
      check($sformatf("v%0d req_ready", n), {31'd0, req_ready0}, 32'd1);
      req_valid0 = 1'b1; req_write0 = v.wr; req_size0 = v.size; req_unsigned0 = v.uns;
      req_addr0 = v.addr; req_wdata0 = v.wdata; req_rd0 = v.rd;
      @(posedge clk);
      #1 req_valid0 = 1'b0;
      lat = 0; re_n = 0; we_n = 0; addr_ok = 1'b1; wd_ok = 1'b1;
      for (int unsigned c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (mem_re0) begin
            re_n++;
            if (mem_addr0 != idx) addr_ok = 1'b0;
         end
         if (mem_we0) begin
            we_n++;
            if (mem_addr0 != idx) addr_ok = 1'b0;
         end else if (mem_wdata0 != 32'd0) wd_ok = 1'b0;
         if (resp_valid0) begin
            lat = c;
            check($sformatf("v%0d resp_data", n), resp_data0, v.data);
            check($sformatf("v%0d resp_rd", n), {27'd0, resp_rd0}, {27'd0, v.exp_rd});
            check($sformatf("v%0d resp_misalign", n), {31'd0, resp_misalign0}, {31'd0, v.mis});
            check($sformatf("v%0d req_ready in resp", n), {31'd0, req_ready0}, 32'd0);
         end
      end
      check($sformatf("v%0d latency", n), lat, v.lat);
      check($sformatf("v%0d mem_re cycles", n), re_n, v.re);
      check($sformatf("v%0d mem_we cycles", n), we_n, v.we);
      check($sformatf("v%0d mem_addr", n), {31'd0, addr_ok}, 32'd1);
      check($sformatf("v%0d mem_wdata idle zero", n), {31'd0, wd_ok}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d memory word", n), mem0[idx], v.mem);
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, " req_ready0"},  {31'd0, req_ready0}, 32'd1);
      check({tag, " busy0"},       {31'd0, busy0}, 32'd0);
      check({tag, " mem_we0"},     {31'd0, mem_we0}, 32'd0);
      check({tag, " mem_re0"},     {31'd0, mem_re0}, 32'd0);
      check({tag, " mem_wdata0"},  mem_wdata0, 32'd0);
      check({tag, " mem_addr0"},   {26'd0, mem_addr0}, 32'd0);
      check({tag, " resp_valid0"}, {31'd0, resp_valid0}, 32'd0);
      check({tag, " resp_data0"},  resp_data0, 32'd0);
      check({tag, " resp_rd0"},    {27'd0, resp_rd0}, 32'd0);
      check({tag, " resp_mis0"},   {31'd0, resp_misalign0}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned acc, last, lat, re_n, we_n;

      rst_n = 1'b0;
      pre_we = 1'b0; pre_idx = '0; pre_val = '0;
      req_valid0 = 0; req_write0 = 0; req_size0 = 2'b10; req_unsigned0 = 0;
      req_addr0 = '0; req_wdata0 = '0; req_rd0 = '0; resp_ready0 = 1'b1;
      req_valid3 = 0; req_write3 = 0; req_size3 = 2'b10; req_unsigned3 = 0;
      req_addr3 = '0; req_wdata3 = '0; req_rd3 = '0; resp_ready3 = 1'b0;

      preload(6'd0, 32'h0BAD_F00D);
      preload(6'd1, 32'h0102_0304);
      preload(6'd4, 32'h0000_0000);
      preload(6'd8, 32'h5A5A_0001);
      preload(6'd16, 32'hA5A5_A5A5);

      #1;
      reset_outputs("reset");
      check("reset req_ready3", {31'd0, req_ready3}, 32'd1);
      check("reset busy3", {31'd0, busy3}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd3, 32'h0, 5'd0, 0, 2, 0, 1, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 5'd7, 32'hDEADBEEF, 5'd7, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b11, 0, 32'h1000_0010, 32'h0, 5'd31, 32'hDEADBEEF, 5'd31, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b10, 0, 32'h06, 32'h0, 5'd9, 32'h0, 5'd9, 1, 1, 0, 0, 32'h0102_0304));
      vecs.push_back(mk(1, 2'b10, 0, 32'h03, 32'hFFFFFFFF, 5'd5, 32'h0, 5'd0, 1, 1, 0, 0, 32'h0BAD_F00D));
      vecs.push_back(mk(1, 2'b10, 0, 32'hFC, 32'h12345678, 5'd0, 32'h0, 5'd0, 0, 2, 0, 1, 32'h12345678));
      vecs.push_back(mk(0, 2'b10, 0, 32'hFC, 32'h0, 5'd1, 32'h12345678, 5'd1, 0, 2, 1, 0, 32'h12345678));
`ifdef LSU_SUBWORD_EN
      vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 5'd2, 32'hFFFFFFDE, 5'd2, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 5'd2, 32'h000000DE, 5'd2, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 5'd4, 32'hFFFFDEAD, 5'd4, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0, 5'd4, 32'h0000BEEF, 5'd4, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b00, 0, 32'h10, 32'h0, 5'd4, 32'hFFFFFFEF, 5'd4, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 5'd6, 32'h0, 5'd0, 0, 3, 1, 1, 32'hDEAD55EF));
      vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'hFFFF1234, 5'd6, 32'h0, 5'd0, 0, 3, 1, 1, 32'h123455EF));
      vecs.push_back(mk(0, 2'b01, 0, 32'h11, 32'h0, 5'd6, 32'h0, 5'd6, 1, 1, 0, 0, 32'h123455EF));
      vecs.push_back(mk(1, 2'b01, 0, 32'h13, 32'h0000FFFF, 5'd6, 32'h0, 5'd0, 1, 1, 0, 0, 32'h123455EF));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 5'd8, 32'h123455EF, 5'd8, 0, 2, 1, 0, 32'h123455EF));
`else
      vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 5'd2, 32'h0, 5'd2, 1, 1, 0, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 5'd6, 32'h0, 5'd0, 1, 1, 0, 0, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0, 5'd4, 32'hDEADBEEF, 5'd4, 0, 2, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, 2'b00, 0, 32'h10, 32'hCAFEF00D, 5'd6, 32'h0, 5'd0, 0, 2, 0, 1, 32'hCAFEF00D));
      vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 5'd8, 32'hCAFEF00D, 5'd8, 0, 2, 1, 0, 32'hCAFEF00D));
`endif

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Back-to-back loads with req_valid held high: one accept every 3 cycles
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1'b0; req_size0 = 2'b10; req_addr0 = 32'h10; req_rd0 = 5'd1;
      acc = 0; last = 0;
      for (int unsigned c = 0; c < 30 && acc < 3; c++) begin
         if (req_ready0) begin
            if (acc > 0) check($sformatf("b2b gap %0d", acc), c - last, 32'd3);
            last = c;
            acc++;
         end
         @(posedge clk);
         #1;
         if (acc == 3) req_valid0 = 1'b0;
         @(negedge clk);
      end
      req_valid0 = 1'b0;
      check("b2b accepts", acc, 32'd3);
      repeat (4) @(negedge clk);

      // MEM_LAT=3 load with writeback stalled for 4 cycles
      req_valid3 = 1'b1; req_write3 = 1'b0; req_size3 = 2'b10; req_addr3 = 32'h20; req_rd3 = 5'd12;
      check("lat3 req_ready", {31'd0, req_ready3}, 32'd1);
      @(posedge clk);
      #1 req_valid3 = 1'b0;
      lat = 0; re_n = 0; we_n = 0;
      for (int unsigned c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (mem_re3) re_n++;
         if (mem_we3) we_n++;
         if (resp_valid3) lat = c;
      end
      check("lat3 latency", lat, 32'd5);
      check("lat3 mem_re cycles", re_n, 32'd4);
      check("lat3 mem_we cycles", we_n, 32'd0);
      for (int unsigned k = 0; k < 4; k++) begin
         check($sformatf("lat3 hold%0d resp_valid", k), {31'd0, resp_valid3}, 32'd1);
         check($sformatf("lat3 hold%0d resp_data", k), resp_data3, 32'h5A5A_0001);
         check($sformatf("lat3 hold%0d resp_rd", k), {27'd0, resp_rd3}, 32'd12);
         check($sformatf("lat3 hold%0d req_ready", k), {31'd0, req_ready3}, 32'd0);
         @(negedge clk);
      end
      resp_ready3 = 1'b1;
      check("lat3 still valid", {31'd0, resp_valid3}, 32'd1);
      @(posedge clk);
      #1;
      check("lat3 idle busy", {31'd0, busy3}, 32'd0);
      check("lat3 idle req_ready", {31'd0, req_ready3}, 32'd1);
      check("lat3 idle resp_valid", {31'd0, resp_valid3}, 32'd0);
      resp_ready3 = 1'b0;

      // Reset asserted while a store is in WRITE
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1'b1; req_size0 = 2'b10; req_addr0 = 32'h40;
      req_wdata0 = 32'h1111_1111; req_rd0 = 5'd0;
      @(posedge clk);
      #1 req_valid0 = 1'b0;
      @(negedge clk);
      check("rst mem_we before", {31'd0, mem_we0}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      reset_outputs("rst mid-write");
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(100, mk(1, 2'b10, 0, 32'h40, 32'h2222_2222, 5'd0, 32'h0, 5'd0, 0, 2, 0, 1, 32'h2222_2222));
      run_vec(101, mk(0, 2'b10, 0, 32'h40, 32'h0, 5'd17, 32'h2222_2222, 5'd17, 0, 2, 1, 0, 32'h2222_2222));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
